// File: rtl/mem_bridge_if.sv
// mem_bridge_if: ready/valid request and one-cycle response channel between the SLC-3 memory port and mem_bridge
interface mem_bridge_if;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Write;
    logic [15:0] Req_Addr;
    logic [15:0] Req_WData;
    logic        Rsp_Valid;
    logic [15:0] Rsp_RData;

    modport master (
        output Req_Valid, Req_Write, Req_Addr, Req_WData,
        input  Req_Ready, Rsp_Valid, Rsp_RData
    );

    modport slave (
        input  Req_Valid, Req_Write, Req_Addr, Req_WData,
        output Req_Ready, Rsp_Valid, Rsp_RData
    );
endinterface

// File: rtl/mem_bridge.sv
// mem_bridge: registered SRAM access sequencer, one read or write at a time, glitch-free non-overlapping strobes.
// Optional feature: define MEM_BRIDGE_POSTED_WR_EN to acknowledge writes in WR_SETUP instead of a trailing RSP cycle.
module mem_bridge #(
    parameter int WAIT_STATES = 2
) (
    input  logic         Clk_i,
    input  logic         Reset_n_i,
    mem_bridge_if.slave  bus,
    output logic [15:0]  SRAM_ADDR_o,
    output logic [15:0]  SRAM_DQ_Out_o,
    output logic         SRAM_DQ_OE_o,
    input  logic [15:0]  SRAM_DQ_In_i,
    output logic         SRAM_OE_N_o,
    output logic         SRAM_WE_N_o,
    output logic         Busy_o
);

    if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("mem_bridge: WAIT_STATES must be within 1..15");
    end

`ifdef MEM_BRIDGE_POSTED_WR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {IDLE, RD_ACC, WR_SETUP, WR_ACC, WR_HOLD, RSP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic        busy_q;
    logic        rsp_valid_q;
    logic [15:0] rdata_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        dq_oe_q;
    logic        oe_n_q;
    logic        we_n_q;

    // Access sequencer: every SRAM strobe and handshake output is a flop, so they change only on clock edges.
    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dq_oe_q     <= 1'b0;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.Req_Valid) begin
                        addr_q  <= bus.Req_Addr;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (bus.Req_Write) begin
                            state_q     <= WR_SETUP;
                            wdata_q     <= bus.Req_WData;
                            dq_oe_q     <= 1'b1;
                            rsp_valid_q <= POSTED;
                        end else begin
                            state_q <= RD_ACC;
                            oe_n_q  <= 1'b0;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                RD_ACC: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RSP;
                        oe_n_q      <= 1'b1;
                        rdata_q     <= SRAM_DQ_In_i;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_SETUP: begin
                    state_q <= WR_ACC;
                    we_n_q  <= 1'b0;
                    cnt_q   <= CNT_LOAD;
                end
                WR_ACC: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= WR_HOLD;
                        we_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_HOLD: begin
                    dq_oe_q <= 1'b0;
                    if (POSTED) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q     <= RSP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RSP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Req_Ready = ready_q;
    assign bus.Rsp_Valid = rsp_valid_q;
    assign bus.Rsp_RData = rdata_q;
    assign SRAM_ADDR_o   = addr_q;
    assign SRAM_DQ_Out_o = wdata_q;
    assign SRAM_DQ_OE_o  = dq_oe_q;
    assign SRAM_OE_N_o   = oe_n_q;
    assign SRAM_WE_N_o   = we_n_q;
    assign Busy_o        = busy_q;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: three bridges (WAIT_STATES 2, 1, 15) against an SRAM model and a transaction-level reference.
module tb_mem_bridge;

`ifdef MEM_BRIDGE_POSTED_WR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  sel;
    logic        req_valid, req_write;
    logic [15:0] req_addr, req_wdata;
    logic [2:0]  ready_a, busy_a, rsp_a, dqoe_a, oen_a, wen_a;
    logic [15:0] rdata_a [3];
    logic [15:0] addr_a [3];
    logic [15:0] dqout_a [3];
    logic [15:0] dq_in;
    logic        ready, busy, rsp, dq_oe, oe_n, we_n;
    logic [15:0] rdata, addr, dq_out;
    logic [15:0] sram [0:65535];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] last_rd [3];
    int          checks = 0;
    int          failures = 0;
    int          accepts;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        mem_bridge_if bi ();
        assign bi.Req_Valid = req_valid && (sel == 2'(k));
        assign bi.Req_Write = req_write;
        assign bi.Req_Addr  = req_addr;
        assign bi.Req_WData = req_wdata;
        assign ready_a[k]   = bi.Req_Ready;
        assign rsp_a[k]     = bi.Rsp_Valid;
        assign rdata_a[k]   = bi.Rsp_RData;
        mem_bridge #(.WAIT_STATES(k == 0 ? 2 : (k == 1 ? 1 : 15))) dut (
            .Clk_i        (clk),
            .Reset_n_i    (rst_n),
            .bus          (bi),
            .SRAM_ADDR_o  (addr_a[k]),
            .SRAM_DQ_Out_o(dqout_a[k]),
            .SRAM_DQ_OE_o (dqoe_a[k]),
            .SRAM_DQ_In_i (dq_in),
            .SRAM_OE_N_o  (oen_a[k]),
            .SRAM_WE_N_o  (wen_a[k]),
            .Busy_o       (busy_a[k])
        );
    end

    assign ready  = ready_a[sel];
    assign busy   = busy_a[sel];
    assign rsp    = rsp_a[sel];
    assign dq_oe  = dqoe_a[sel];
    assign oe_n   = oen_a[sel];
    assign we_n   = wen_a[sel];
    assign rdata  = rdata_a[sel];
    assign addr   = addr_a[sel];
    assign dq_out = dqout_a[sel];
    assign dq_in  = oe_n ? 16'hDEAD : sram[addr];

    // SRAM model: power-on pattern restored while reset is low, written on every clock with WE_N low.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 65536; i++) sram[i] <= 16'(i) ^ 16'h5A5A;
            sram[16'h0010] <= 16'hBEEF;
        end else if (!we_n) begin
            sram[addr] <= dq_out;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) accepts <= 0;
        else if (req_valid && ready) accepts <= accepts + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int ws(input logic [1:0] s);
        return s == 2'd0 ? 2 : (s == 2'd1 ? 1 : 15);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a == 16'h0010 ? 16'hBEEF : a ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
        end
    endtask

    task automatic run(input bit wr, input logic [15:0] a, input logic [15:0] d, input bit hold);
        int w, rel, oe_cnt, we_cnt, oe_first, we_first, dqoe_cnt, rsp_cnt, rsp_rel, ready_rel, bad;
        logic [15:0] exp_rd, rd;
        w = ws(sel);
        oe_cnt = 0; we_cnt = 0; oe_first = 0; we_first = 0; dqoe_cnt = 0;
        rsp_cnt = 0; rsp_rel = 0; ready_rel = 0; bad = 0; rd = '0;
        req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
        rel = 0;
        while (!ready && rel < 40) begin
            @(negedge clk);
            rel++;
        end
        chk("accept_ready", 32'(ready), 1);
        if (!ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        exp_rd = ref_rd(a);
        if (wr) ref_mem[a] = d;
        if (!hold) begin
            req_valid = 1'b0; req_write = ~wr; req_addr = ~a; req_wdata = ~d;
        end
        for (rel = 1; rel <= 40; rel++) begin
            @(negedge clk);
            if (!oe_n) begin oe_cnt++; if (oe_first == 0) oe_first = rel; end
            if (!we_n) begin we_cnt++; if (we_first == 0) we_first = rel; end
            if (dq_oe) dqoe_cnt++;
            if (rsp) begin rsp_cnt++; if (rsp_rel == 0) begin rsp_rel = rel; rd = rdata; end end
            if ((!oe_n && !we_n) || (dq_oe && !oe_n) || (busy === ready)) bad++;
            if ((!oe_n || !we_n || dq_oe) && addr !== a) bad++;
            if (ready) begin ready_rel = rel; break; end
        end
        chk("ready_return", ready_rel, wr ? (POSTED ? w + 3 : w + 4) : w + 2);
        chk("rsp_cycle", rsp_rel, wr ? (POSTED ? 1 : w + 3) : w + 1);
        chk("rsp_count", rsp_cnt, 1);
        chk("oe_width", oe_cnt, wr ? 0 : w);
        chk("oe_first", oe_first, wr ? 0 : 1);
        chk("we_width", we_cnt, wr ? w : 0);
        chk("we_first", we_first, wr ? 2 : 0);
        chk("dq_oe_width", dqoe_cnt, wr ? w + 2 : 0);
        chk("invariants", bad, 0);
        if (wr) begin
            chk("rdata_hold", rd, last_rd[sel]);
            chk("sram_store", sram[a], d);
        end else begin
            chk("read_data", rd, exp_rd);
            last_rd[sel] = exp_rd;
        end
    endtask

    initial begin
        int acc0, n;
        bit prev_hold, wr, hold;
        logic [15:0] a;
        rst_n = 1'b0; sel = 2'd0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        last_rd = '{16'h0, 16'h0, 16'h0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #0;
            chk("rst_ready", 32'(ready), 1);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rsp", 32'(rsp), 0);
            chk("rst_strobes", {29'd0, oe_n, we_n, dq_oe}, 32'b110);
            chk("rst_addr_data", {addr, rdata}, 0);
        end
        sel = 2'd0;
        rst_n = 1'b1;

        run(1'b0, 16'h0010, 16'h0000, 1'b0);
        run(1'b1, 16'h1234, 16'hA5A5, 1'b0);

        acc0 = accepts;
        run(1'b0, 16'h1234, 16'h0000, 1'b1);
        run(1'b1, 16'h1234, 16'h0F0F, 1'b0);
        chk("held_two_accepts", accepts - acc0, 2);
        run(1'b0, 16'h1234, 16'h0000, 1'b0);

        run(1'b1, 16'h0042, 16'h1357, 1'b0);
        run(1'b0, 16'h0042, 16'h0000, 1'b0);

        req_write = 1'b1; req_addr = 16'h0300; req_wdata = 16'hC3C3; req_valid = 1'b1;
        n = 0;
        while (!ready && n < 40) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_in_wr_acc", 32'(we_n), 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_we_n", 32'(we_n), 1);
        chk("abort_dq_oe", 32'(dq_oe), 0);
        chk("abort_ready", 32'(ready), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_oe_rsp", {30'd0, oe_n, rsp}, 32'b10);
        chk("abort_addr_data", {addr, dq_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_mem.delete();
        last_rd = '{16'h0, 16'h0, 16'h0};
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp) n++;
        end
        chk("abort_no_rsp", n, 0);

        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            prev_hold = 1'b0;
            for (int i = 0; i < 16; i++) begin
                wr = 1'($urandom_range(0, 1));
                hold = ($urandom_range(0, 3) == 0);
                a = 16'h0200 + 16'($urandom_range(0, 7));
                if (!prev_hold) repeat ($urandom_range(0, 2)) @(negedge clk);
                run(wr, a, 16'($urandom), hold && i != 15);
                prev_hold = hold && i != 15;
            end
            req_valid = 1'b0;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Registered SRAM access bridge between the SLC-3 datapath's memory port (MAR/MDR, driven by the ISDU memory states) and the physical SRAM / Mem2IO path. It accepts one read or write request at a time through a ready/valid handshake. It sequences SRAM address, data, output-enable and write-enable over a parameterised number of wait states, then returns a one-cycle response. All SRAM strobes are registered, so they are glitch-free and never overlap.

## Interface

Parameters:
- WAIT_STATES, 2, number of cycles the OE_N/WE_N strobe is held low; legal range 1..15; any other value is an elaboration error.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset_n  in  1  one clock; reset is synchronous and active-low.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  bridge can accept a request; high only in IDLE.
- Req_Write  in  1  1 = write, 0 = read.
- Req_Addr  in  16  word address (MAR).
- Req_WData  in  16  write data (MDR).
- Rsp_Valid  out  1  one-cycle pulse: read data valid / write complete.
- Rsp_RData  out  16  read data; holds its value until the next read response.
- SRAM_ADDR  out  16  registered SRAM address.
- SRAM_DQ_Out  out  16  registered write data.
- SRAM_DQ_OE  out  1  data-bus drive enable, high during the write phases.
- SRAM_DQ_In  in  16  SRAM read data.
- SRAM_OE_N  out  1  active-low output enable.
- SRAM_WE_N  out  1  active-low write enable.
- Busy  out  1  high in any state other than IDLE.

## Operation

- States are IDLE, RD_ACC, WR_SETUP, WR_ACC, WR_HOLD, RSP. A 4-bit wait counter runs alongside the state machine.
- Accept: Req_Valid & Req_Ready at a rising edge. At that edge Req_Addr, Req_WData and Req_Write are captured. Request inputs are ignored at all other times and may change after acceptance.
- Read path: IDLE -> RD_ACC.
  - SRAM_OE_N = 0 for WAIT_STATES cycles.
  - SRAM_DQ_In is sampled into Rsp_RData at the edge ending the last RD_ACC cycle.
  - Then RSP -> IDLE.
- Write path: IDLE -> WR_SETUP -> WR_ACC -> WR_HOLD -> RSP -> IDLE.
  - WR_SETUP (1 cycle): address and data valid, SRAM_DQ_OE = 1, SRAM_WE_N = 1.
  - WR_ACC (WAIT_STATES cycles): SRAM_WE_N = 0.
  - WR_HOLD (1 cycle): SRAM_WE_N = 1, with address, data and SRAM_DQ_OE still held.
- RSP lasts one cycle: Rsp_Valid = 1, Req_Ready = 0.
- Invariants:
  - SRAM_OE_N and SRAM_WE_N are never both 0.
  - SRAM_DQ_OE is never 1 while SRAM_OE_N = 0.
  - SRAM_ADDR is stable from the first through the last cycle of an access.
- Wait counter: loaded with WAIT_STATES-1 on entry to RD_ACC/WR_ACC and decrements each cycle. The state exits when the counter is 0; it never wraps.
- Reset (Reset_n low at an edge), effective from that edge, including mid-access:
  - state = IDLE, Req_Ready = 1, Busy = 0;
  - Rsp_Valid = 0, Rsp_RData = 0;
  - SRAM_ADDR = 0, SRAM_DQ_Out = 0, SRAM_DQ_OE = 0;
  - SRAM_OE_N = 1, SRAM_WE_N = 1.
  - An aborted write produces no response.

## Timing

- Request accepted at edge T.
- Read: SRAM_OE_N low during cycles T+1..T+W; Rsp_Valid high in cycle T+W+1; Req_Ready high again at T+W+2.
- Write: WR_SETUP in T+1; SRAM_WE_N low during T+2..T+W+1; WR_HOLD in T+W+2; Rsp_Valid in T+W+3.
- Back-to-back throughput: reads every W+2 cycles, writes every W+4 cycles.
- A request held during RSP is accepted on the first IDLE cycle, with no lost or duplicated request.
- Req_Ready is decoded from state only; it has no combinational path from Req_Valid.

## Configuration

- MEM_BRIDGE_POSTED_WR_EN defined:
  - A write's Rsp_Valid fires in cycle T+1, with WR_SETUP.
  - The SRAM write sequence then completes normally, with no second response.
  - Req_Ready stays low and Busy stays high until WR_HOLD finishes; the next request is accepted at T+W+3.
  - Reads are unchanged.
- Undefined: writes respond in RSP as above.

## Test plan

- Reset, then read Addr 0x0010 with WAIT_STATES=2 and SRAM model returning 0xBEEF -> OE_N low exactly 2 cycles; Rsp_Valid at T+3 with Rsp_RData = 0xBEEF; WE_N stays 1.
- Write Addr 0x1234, Data 0xA5A5 -> WR_SETUP 1 cycle, WE_N low 2 cycles, hold 1 cycle; SRAM model stores 0xA5A5 at 0x1234; Rsp_Valid at T+5.
- Req_Valid held continuously with a read followed by a write to the same address -> exactly two accepts, no overlap of OE_N/WE_N; readback returns the prior value.
- Reset_n driven low during the second WR_ACC cycle -> at that edge WE_N = 1, DQ_OE = 0, Req_Ready = 1; no Rsp_Valid is ever produced for the aborted write.
- WAIT_STATES=1 and WAIT_STATES=15 sweep -> strobe widths of 1 and 15 cycles respectively; the counter never wraps.
- With MEM_BRIDGE_POSTED_WR_EN, write then immediate read -> write Rsp_Valid at T+1; read accepted at T+W+3; it returns the newly written data.
